// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: paces start pulses to the single-wire controller,
// retries failed reads, recovers the controller after a timeout and holds
// the last good humidity/temperature pair for the display/UART side.
module dht11_read_scheduler #(
    parameter int CLK_PER_MS   = 100_000,
    parameter int PERIOD_MS    = 2000,
    parameter int MIN_GAP_MS   = 1000,
    parameter int RETRY_GAP_MS = 1100,
    parameter int TIMEOUT_MS   = 30,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        req_now,
    output logic        dht_start,
    output logic        dht_rst,
    input  logic        dht_done,
    input  logic        dht_valid,
    input  logic [15:0] dht_hum,
    input  logic [15:0] dht_temp,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        data_valid,
    output logic        update,
    output logic        err_timeout,
    output logic        err_fail,
    output logic [7:0]  fail_cnt,
    output logic        busy,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GAP = 3'd1,
        TRIGGER  = 3'd2,
        BUSY     = 3'd3,
        RECOVER  = 3'd4
    } state_t;

    localparam int              TICK_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_MS - 1);
    localparam logic [15:0]     PERIOD    = 16'(PERIOD_MS);
    localparam logic [15:0]     MIN_GAP   = 16'(MIN_GAP_MS);
    localparam logic [15:0]     RETRY_GAP = 16'(RETRY_GAP_MS);
    localparam logic [15:0]     TIMEOUT   = 16'(TIMEOUT_MS);
    localparam logic [7:0]      RETRY_MAX = 8'(MAX_RETRY);

    state_t              cur_state;
    state_t              nxt_state;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [15:0]         ms_cnt;
    logic [15:0]         gap;
    logic [15:0]         gap_nxt;
    logic                pending;
    logic [7:0]          retry_cnt;
    logic [1:0]          rec_cnt;
    logic                load_data;
    logic                retry_decide;
    logic                retry_inc;
    logic                retry_clr;
    logic                fail_evt;
    logic                timeout_evt;

    assign tick      = (tick_cnt == TICK_LAST);
    assign dht_start = (cur_state == TRIGGER);
    assign dht_rst   = (cur_state == RECOVER);
    assign busy      = (cur_state == TRIGGER) || (cur_state == BUSY) || (cur_state == RECOVER);
    assign state     = cur_state;

    // Free-running prescaler producing a one-clock tick every millisecond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_state <= IDLE;
        else
            cur_state <= nxt_state;
    end

    // Next-state logic plus the one-cycle actions taken on each transition.
    always_comb begin
        nxt_state    = cur_state;
        gap_nxt      = gap;
        load_data    = 1'b0;
        retry_decide = 1'b0;
        retry_inc    = 1'b0;
        retry_clr    = 1'b0;
        fail_evt     = 1'b0;
        timeout_evt  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (enable) begin
                    nxt_state = WAIT_GAP;
                    gap_nxt   = PERIOD;
                end
            end
            WAIT_GAP: begin
                if (!enable)
                    nxt_state = IDLE;
                else if ((ms_cnt >= gap) || ((pending || req_now) && (ms_cnt >= MIN_GAP)))
                    nxt_state = TRIGGER;
            end
            TRIGGER: nxt_state = BUSY;
            BUSY: begin
                if (dht_done) begin
                    if (dht_valid) begin
                        load_data = 1'b1;
                        retry_clr = 1'b1;
                        gap_nxt   = PERIOD;
                        nxt_state = enable ? WAIT_GAP : IDLE;
                    end else begin
                        retry_decide = 1'b1;
                    end
                end else if (ms_cnt == TIMEOUT) begin
                    timeout_evt = 1'b1;
                    nxt_state   = RECOVER;
                end
            end
            RECOVER: begin
                if (rec_cnt == 2'd3)
                    retry_decide = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
        if (retry_decide) begin
            if (retry_cnt < RETRY_MAX) begin
                retry_inc = 1'b1;
                gap_nxt   = RETRY_GAP;
            end else begin
                fail_evt  = 1'b1;
                retry_clr = 1'b1;
                gap_nxt   = PERIOD;
            end
            nxt_state = enable ? WAIT_GAP : IDLE;
        end
    end

    // Millisecond counter restarts on every state change and saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ms_cnt <= '0;
        else if (nxt_state != cur_state)
            ms_cnt <= '0;
        else if (tick && (ms_cnt != 16'hFFFF))
            ms_cnt <= ms_cnt + 16'd1;
    end

    // Holds the controller in local reset for exactly four clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rec_cnt <= '0;
        else if (cur_state != RECOVER)
            rec_cnt <= '0;
        else
            rec_cnt <= rec_cnt + 2'd1;
    end

    // Early-read request is only remembered while waiting and dropped on leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else
            pending <= (nxt_state == WAIT_GAP) &&
                       (pending || ((cur_state == WAIT_GAP) && req_now));
    end

    // Retry bookkeeping and the gap that the next WAIT_GAP visit must honour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
            gap       <= '0;
        end else begin
            gap <= gap_nxt;
            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + 8'd1;
        end
    end

    // Result registers and status pulses; failed reads leave the data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            humidity    <= '0;
            temperature <= '0;
            data_valid  <= 1'b0;
            update      <= 1'b0;
            err_timeout <= 1'b0;
            err_fail    <= 1'b0;
            fail_cnt    <= '0;
        end else begin
            update      <= load_data;
            err_timeout <= timeout_evt;
            err_fail    <= fail_evt;
            if (load_data) begin
                humidity    <= dht_hum;
                temperature <= dht_temp;
                data_valid  <= 1'b1;
            end
            if (fail_evt && (fail_cnt != 8'hFF))
                fail_cnt <= fail_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Self-checking bench for dht11_read_scheduler with scaled-down timing
// (10 clks per ms) and a behavioural DHT11 controller model.
module tb_dht11_read_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        req_now = 1'b0;
    logic        dht_start;
    logic        dht_rst;
    logic        dht_done = 1'b0;
    logic        dht_valid = 1'b0;
    logic [15:0] dht_hum = 16'h0000;
    logic [15:0] dht_temp = 16'h0000;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        data_valid;
    logic        update;
    logic        err_timeout;
    logic        err_fail;
    logic [7:0]  fail_cnt;
    logic        busy;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    // controller model controls
    bit          model_answer = 1'b0;
    int          countdown = -1;
    int          resp_delay = 30;
    bit          valid_seq[$];
    logic [15:0] model_hum = 16'h0000;
    logic [15:0] model_temp = 16'h0000;

    // monitor counters
    int n_start = 0, n_update = 0, n_timeout = 0, n_fail = 0, n_rst = 0;
    int since_start = 0, since_done = 0;
    bit have_done = 1'b0, last_valid = 1'b0;
    int retry_gaps[$];
    int to_lat[$];

    dht11_read_scheduler #(
        .CLK_PER_MS(10), .PERIOD_MS(20), .MIN_GAP_MS(10),
        .RETRY_GAP_MS(12), .TIMEOUT_MS(5), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_now(req_now),
        .dht_start(dht_start), .dht_rst(dht_rst), .dht_done(dht_done),
        .dht_valid(dht_valid), .dht_hum(dht_hum), .dht_temp(dht_temp),
        .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
        .update(update), .err_timeout(err_timeout), .err_fail(err_fail),
        .fail_cnt(fail_cnt), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    // Controller model: answers resp_delay clks after a start, validity from valid_seq.
    always @(negedge clk) begin
        dht_done = 1'b0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                dht_done  = 1'b1;
                dht_valid = (valid_seq.size() > 0) ? valid_seq.pop_front() : 1'b1;
                dht_hum   = dht_valid ? model_hum : 16'hDEAD;
                dht_temp  = dht_valid ? model_temp : 16'hBEEF;
                countdown = -1;
            end
        end
        if (dht_start && model_answer)
            countdown = resp_delay;
    end

    // Event monitor, sampling mid-cycle after the model has driven.
    always begin
        @(negedge clk);
        #2;
        since_start++;
        since_done++;
        if (dht_start) begin
            n_start++;
            if (have_done && !last_valid)
                retry_gaps.push_back(since_done);
            since_start = 0;
        end
        if (dht_done) begin
            since_done = 0;
            have_done  = 1'b1;
            last_valid = dht_valid;
        end
        if (err_timeout) begin
            n_timeout++;
            to_lat.push_back(since_start);
        end
        if (update)   n_update++;
        if (err_fail) n_fail++;
        if (dht_rst)  n_rst++;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic settle();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_start(input int limit, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dht_start && k < limit);
        if (!dht_start) k = -1;
    endtask

    task automatic wait_update(input int limit, output bit seen);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!update && k < limit);
        seen = update;
    endtask

    task automatic wait_wait_gap(input int limit, output bit seen);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (state != 3'd1 && k < limit);
        seen = (state == 3'd1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dht_start, dht_rst, update, err_timeout, err_fail, data_valid, busy} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {dht_start, dht_rst, update, err_timeout, err_fail, data_valid, busy});
        end
        checks++;
        if ({humidity, temperature, fail_cnt, state} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: hum=%h temp=%h fail_cnt=%0d state=%0d expected all 0",
                     humidity, temperature, fail_cnt, state);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 3'd0 || dht_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_when_disabled: state=%0d start=%b expected 0/0", state, dht_start);
        end
    endtask

    task automatic test_single_read();
        int k;
        bit seen;
        model_hum    = 16'h3700;
        model_temp   = 16'h1A05;
        model_answer = 1'b1;
        enable       = 1'b1;
        wait_start(400, k);
        checks++;
        if (k < 190 || k > 205) begin
            errors++;
            $display("[TB] FAIL first_start_delay: got %0d clks expected 190..205", k);
        end
        wait_update(100, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL first_update: got no update pulse expected one");
        end
        checks++;
        if (humidity !== 16'h3700 || temperature !== 16'h1A05 || data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_data: hum=%h temp=%h dv=%b expected 3700/1a05/1",
                     humidity, temperature, data_valid);
        end
        settle();
        checks++;
        if (n_timeout !== 0 || n_rst !== 0 || fail_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL first_no_errors: timeouts=%0d rst_clks=%0d fail_cnt=%0d expected 0/0/0",
                     n_timeout, n_rst, fail_cnt);
        end
    endtask

    task automatic test_retry_ok();
        bit seen;
        int k;
        settle();
        n_start = 0; n_update = 0; n_fail = 0;
        retry_gaps.delete();
        valid_seq  = '{1'b0, 1'b0, 1'b1};
        model_hum  = 16'h3A00;
        model_temp = 16'h1B02;
        k = 0;
        while (n_start < 2 && k < 800) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (n_start < 2 || humidity !== 16'h3700 || n_update !== 0) begin
            errors++;
            $display("[TB] FAIL retry_bad_read_kept: starts=%0d hum=%h updates=%0d expected >=2/3700/0",
                     n_start, humidity, n_update);
        end
        wait_update(400, seen);
        checks++;
        if (!seen || humidity !== 16'h3A00 || temperature !== 16'h1B02) begin
            errors++;
            $display("[TB] FAIL retry_data: seen=%b hum=%h temp=%h expected 1/3a00/1b02",
                     seen, humidity, temperature);
        end
        settle();
        checks++;
        if (n_update !== 1 || n_fail !== 0 || fail_cnt !== 8'd0 || n_start !== 3) begin
            errors++;
            $display("[TB] FAIL retry_counts: updates=%0d fails=%0d fail_cnt=%0d starts=%0d expected 1/0/0/3",
                     n_update, n_fail, fail_cnt, n_start);
        end
        checks++;
        if (retry_gaps.size() != 2) begin
            errors++;
            $display("[TB] FAIL retry_gap_count: got %0d expected 2", retry_gaps.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (retry_gaps[i] < 110 || retry_gaps[i] > 125) begin
                    errors++;
                    $display("[TB] FAIL retry_gap_%0d: got %0d clks expected 110..125", i, retry_gaps[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        settle();
        n_start = 0; n_update = 0; n_fail = 0; n_timeout = 0; n_rst = 0;
        to_lat.delete();
        model_answer = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!err_fail && k < 2000);
        checks++;
        if (!err_fail) begin
            errors++;
            $display("[TB] FAIL timeout_err_fail: got no err_fail within %0d clks expected one", k);
        end
        settle();
        checks++;
        if (n_start !== 3 || n_timeout !== 3 || n_rst !== 12 || n_fail !== 1) begin
            errors++;
            $display("[TB] FAIL timeout_counts: starts=%0d timeouts=%0d rst_clks=%0d fails=%0d expected 3/3/12/1",
                     n_start, n_timeout, n_rst, n_fail);
        end
        checks++;
        if (fail_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL timeout_fail_cnt: got %0d expected 1", fail_cnt);
        end
        checks++;
        if (humidity !== 16'h3A00 || temperature !== 16'h1B02 || data_valid !== 1'b1 || n_update !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_data_kept: hum=%h temp=%h dv=%b updates=%0d expected 3a00/1b02/1/0",
                     humidity, temperature, data_valid, n_update);
        end
        checks++;
        if (to_lat.size() == 0 || to_lat[0] < 42 || to_lat[0] > 53) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d clks expected 42..53",
                     (to_lat.size() == 0) ? -1 : to_lat[0]);
        end
    endtask

    task automatic test_req_now();
        int k;
        int c;
        bit seen;
        model_answer = 1'b1;
        model_hum    = 16'h3C00;
        model_temp   = 16'h1C00;
        wait_start(400, k);
        wait_wait_gap(100, seen);
        c = 0;
        while (!dht_start && c < 300) begin
            @(negedge clk);
            c++;
            if (c == 30) req_now = 1'b1;
            if (c == 31) req_now = 1'b0;
        end
        req_now = 1'b0;
        checks++;
        if (!seen || c < 88 || c > 105) begin
            errors++;
            $display("[TB] FAIL req_now_early: got start %0d clks after entry expected 88..105", c);
        end
        wait_wait_gap(100, seen);
        repeat (150) @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL req_now_still_waiting: state=%0d expected 1", state);
        end
        req_now = 1'b1;
        @(negedge clk);
        req_now = 1'b0;
        checks++;
        if (state !== 3'd2 || dht_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_now_immediate: state=%0d start=%b expected 2/1", state, dht_start);
        end
    endtask

    task automatic test_disable_busy();
        bit seen;
        int s0;
        model_hum  = 16'h2811;
        model_temp = 16'h0F09;
        repeat (10) @(negedge clk);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("[TB] FAIL disable_in_busy: state=%0d expected 3", state);
        end
        enable = 1'b0;
        wait_update(100, seen);
        checks++;
        if (!seen || state !== 3'd0 || humidity !== 16'h2811 || temperature !== 16'h0F09) begin
            errors++;
            $display("[TB] FAIL disable_completes: seen=%b state=%0d hum=%h temp=%h expected 1/0/2811/0f09",
                     seen, state, humidity, temperature);
        end
        settle();
        s0 = n_start;
        repeat (300) @(negedge clk);
        settle();
        checks++;
        if (n_start !== s0 || state !== 3'd0) begin
            errors++;
            $display("[TB] FAIL disable_no_start: starts=%0d state=%0d expected %0d/0", n_start, state, s0);
        end
    endtask

    task automatic test_reset_busy();
        int k;
        enable = 1'b1;
        wait_start(400, k);
        repeat (10) @(negedge clk);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("[TB] FAIL rst_pre_busy: state=%0d expected 3", state);
        end
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if ({humidity, temperature, fail_cnt, state} !== 43'd0 ||
            {dht_start, dht_rst, update, err_timeout, err_fail, data_valid, busy} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL rst_async: hum=%h temp=%h fail_cnt=%0d state=%0d busy=%b dv=%b expected all 0",
                     humidity, temperature, fail_cnt, state, busy, data_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_start(400, k);
        checks++;
        if (k < 190 || k > 205) begin
            errors++;
            $display("[TB] FAIL rst_restart_delay: got %0d clks expected 190..205", k);
        end
        checks++;
        if (humidity !== 16'h0000 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_done_ignored: hum=%h dv=%b expected 0000/0", humidity, data_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_retry_ok();
        test_timeout();
        test_req_now();
        test_disable_busy();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
